// File: rtl/hack_cpu_garage.sv
// Hack-ISA computer: single-cycle 16-bit CPU with 1024x16 instruction ROM and 1024x16 data RAM.
// Optional macro CPU_GARAGE_INSTR_CNT_EN adds a free-running 32-bit instruction counter.

module hack_cpu_garage_rom #(
    parameter int unsigned ROM_DEPTH = 1024,
    localparam int unsigned ROM_AW   = $clog2(ROM_DEPTH)
) (
    input  logic [ROM_AW-1:0] addr,
    output logic [15:0]       data
);

    // Contents are preloaded externally; there is no write port.
    logic [15:0] mem [ROM_DEPTH-1:0];

    assign data = mem[addr];

endmodule

module hack_cpu_garage #(
    parameter int unsigned ROM_DEPTH = 1024,
    parameter int unsigned RAM_DEPTH = 1024
) (
    input logic Clk,
    input logic Reset
);

    localparam int unsigned ROM_AW = $clog2(ROM_DEPTH);
    localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);

    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [14:0] pc_q, pc_d;

    logic [15:0]       instr;
    logic [15:0]       in_m;
    logic [15:0]       cpu_out_m;
    logic [RAM_AW-1:0] ram_address;
    logic              we;

    logic [15:0] ram [RAM_DEPTH];

    logic        is_c;
    logic [15:0] x, y;
    logic        zr, ng, taken;
    logic [14:0] pc_inc;

    hack_cpu_garage_rom #(
        .ROM_DEPTH(ROM_DEPTH)
    ) rom_inst (
        .addr(pc_q[ROM_AW-1:0]),
        .data(instr)
    );

    assign ram_address = a_q[RAM_AW-1:0];
    assign in_m        = ram[ram_address];
    assign is_c        = instr[15];
    assign pc_inc      = pc_q + 15'd1;

    // Hack ALU: instr[11:6] = zx, nx, zy, ny, f, no.
    always_comb begin
        x = d_q;
        y = instr[12] ? in_m : a_q;
        if (instr[11]) x = 16'h0000;
        if (instr[10]) x = ~x;
        if (instr[9])  y = 16'h0000;
        if (instr[8])  y = ~y;
        cpu_out_m = instr[7] ? (x + y) : (x & y);
        if (instr[6]) cpu_out_m = ~cpu_out_m;
    end

    assign zr    = (cpu_out_m == 16'h0000);
    assign ng    = cpu_out_m[15];
    assign taken = (instr[2] & ng) | (instr[1] & zr) | (instr[0] & ~ng & ~zr);
    assign we    = is_c & instr[3] & ~Reset;

    always_comb begin
        a_d  = a_q;
        d_d  = d_q;
        pc_d = pc_inc;
        if (!is_c) begin
            a_d = {1'b0, instr[14:0]};
        end else begin
            if (instr[5]) a_d = cpu_out_m;
            if (instr[4]) d_d = cpu_out_m;
            // Jump target is the A value before this instruction's update.
            if (taken) pc_d = a_q[14:0];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_q  <= 16'h0000;
            d_q  <= 16'h0000;
            pc_q <= 15'h0000;
        end else begin
            a_q  <= a_d;
            d_q  <= d_d;
            pc_q <= pc_d;
        end
    end

    // Write address uses the pre-update A, matching the read side of M.
    always_ff @(posedge Clk) begin
        if (we) ram[ram_address] <= cpu_out_m;
    end

`ifdef CPU_GARAGE_INSTR_CNT_EN
    logic [31:0] instr_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) instr_cnt <= 32'd0;
        else       instr_cnt <= instr_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hack_cpu_garage.sv
// Bench for hack_cpu_garage: expected RAM writes go into a scoreboard queue, a negedge
// monitor pops and compares them; register/PC state is checked at program milestones.

module tb_hack_cpu_garage;

    logic Clk;
    logic Reset;

    int n_checks;
    int n_fail;

    logic [25:0] exp_q [$];

    // Hack comp fields (a=0 forms; a=1 swaps A for M)
    localparam logic [5:0] C_ZERO = 6'b101010, C_ONE  = 6'b111111, C_NEG1 = 6'b111010;
    localparam logic [5:0] C_D    = 6'b001100, C_A    = 6'b110000, C_NOTD = 6'b001101;
    localparam logic [5:0] C_NOTA = 6'b110001, C_NEGD = 6'b001111, C_NEGA = 6'b110011;
    localparam logic [5:0] C_DP1  = 6'b011111, C_AP1  = 6'b110111, C_DM1  = 6'b001110;
    localparam logic [5:0] C_AM1  = 6'b110010, C_DPA  = 6'b000010, C_DMA  = 6'b010011;
    localparam logic [5:0] C_AMD  = 6'b000111, C_DANDA = 6'b000000, C_DORA = 6'b010101;

    hack_cpu_garage dut (
        .Clk  (Clk),
        .Reset(Reset)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [15:0] ci(input logic a, input logic [5:0] c, input logic [2:0] d,
                                       input logic [2:0] j);
        return {3'b111, a, c, d, j};
    endfunction

    function automatic logic [15:0] ai(input int unsigned v);
        return {1'b0, v[14:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic put(input int unsigned addr, input logic [15:0] w);
        dut.rom_inst.mem[addr] = w;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) dut.rom_inst.mem[i] = 16'h0000;
    endtask

    task automatic push_wr(input logic [9:0] addr, input logic [15:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic hold_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic release_reset();
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic wait_pc(input string name, input logic [14:0] target, input int budget);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (dut.pc_q == target) begin
                hit = 1'b1;
                break;
            end
        end
        check(name, {31'd0, hit}, 32'd1);
    endtask

    // Monitor: every asserted write must match the head of the scoreboard.
    always @(negedge Clk) begin
        if (!Reset && dut.we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                         dut.ram_address, dut.cpu_out_m);
            end else begin
                check("ram_write", {6'd0, dut.ram_address, dut.cpu_out_m}, {6'd0, exp_q.pop_front()});
            end
        end
    end

    logic [5:0]  ops  [18];
    logic [15:0] outs [18];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset    = 1'b1;
        ops  = '{C_ZERO, C_ONE, C_NEG1, C_D, C_A, C_NOTD, C_NOTA, C_NEGD, C_NEGA,
                 C_DP1, C_AP1, C_DM1, C_AM1, C_DPA, C_DMA, C_AMD, C_DANDA, C_DORA};
        outs = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0011, 16'h0003, 16'hFFEE, 16'hFFFC,
                 16'hFFEF, 16'hFFFD, 16'h0012, 16'h0004, 16'h0010, 16'h0002, 16'h0014,
                 16'h000E, 16'hFFF2, 16'h0001, 16'h0013};

        // Program 1: load, store, read back
        clear_rom();
        put(0, ai(5));   put(1, ci(0, C_A, 3'b010, 3'b000));
        put(2, ai(100)); put(3, ci(0, C_A, 3'b010, 3'b000));
        put(4, ai(7));   put(5, ci(0, C_D, 3'b001, 3'b000));
        put(6, ci(0, C_ZERO, 3'b010, 3'b000));
        put(7, ci(1, C_A, 3'b010, 3'b000));
        put(8, ai(8));   put(9, ci(0, C_ZERO, 3'b000, 3'b111));
        push_wr(10'd7, 16'd100);
        repeat (2) @(posedge Clk);
        #1;
        check("reset_pc", {17'd0, dut.pc_q}, 32'd0);
        check("reset_a", {16'd0, dut.a_q}, 32'd0);
        check("reset_d", {16'd0, dut.d_q}, 32'd0);
        check("reset_we", {31'd0, dut.we}, 32'd0);
        release_reset();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("p1_a_after_2", {16'd0, dut.a_q}, 32'd5);
        check("p1_d_after_2", {16'd0, dut.d_q}, 32'd5);
        check("p1_we_idle", {31'd0, dut.we}, 32'd0);
        wait_pc("p1_halt", 15'd8, 50);
        check("p1_d_readback", {16'd0, dut.d_q}, 32'd100);
        check("p1_drain", exp_q.size(), 32'd0);

        // Program 2: all 18 ALU ops with D=0x11, A=3, each stored to M
        hold_reset();
        clear_rom();
        put(0, ai(16'h11)); put(1, ci(0, C_A, 3'b010, 3'b000)); put(2, ai(3));
        for (int i = 0; i < 18; i++) begin
            put(3 + i, ci(0, ops[i], 3'b001, 3'b000));
            push_wr(10'd3, outs[i]);
        end
        put(21, ai(21)); put(22, ci(0, C_ZERO, 3'b000, 3'b111));
        release_reset();
        wait_pc("p2_halt", 15'd21, 100);
        check("p2_drain", exp_q.size(), 32'd0);

        // Program 3: JLT taken, JGT not taken, JMP, then AM=M+1
        hold_reset();
        clear_rom();
        put(0, ci(0, C_NEG1, 3'b010, 3'b000));
        put(1, ai(20));  put(2, ci(0, C_D, 3'b000, 3'b100));
        put(3, ai(99));  put(4, ci(0, C_D, 3'b001, 3'b000));
        put(20, ci(0, C_ZERO, 3'b010, 3'b000));
        put(21, ai(30)); put(22, ci(0, C_D, 3'b000, 3'b001));
        put(23, ai(40)); put(24, ci(0, C_D, 3'b001, 3'b000));
        put(25, ai(33)); put(26, ci(0, C_ZERO, 3'b000, 3'b111));
        put(27, ai(41)); put(28, ci(0, C_D, 3'b001, 3'b000));
        put(33, ai(9));  put(34, ci(0, C_A, 3'b010, 3'b000));
        put(35, ai(3));  put(36, ci(0, C_D, 3'b001, 3'b000));
        put(37, ci(1, C_AP1, 3'b101, 3'b000));
        put(38, ci(0, C_A, 3'b010, 3'b000));
        put(39, ai(39)); put(40, ci(0, C_ZERO, 3'b000, 3'b111));
        push_wr(10'd40, 16'd0);
        push_wr(10'd3, 16'd9);
        push_wr(10'd3, 16'd10);
        release_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("p3_jlt_taken_pc", {17'd0, dut.pc_q}, 32'd20);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("p3_jgt_fallthrough_pc", {17'd0, dut.pc_q}, 32'd23);
        wait_pc("p3_halt", 15'd39, 100);
        check("p3_am_incr_a", {16'd0, dut.d_q}, 32'd10);
        check("p3_drain", exp_q.size(), 32'd0);

        // Program 4: async reset mid-run; RAM[7]=100 survives, restart writes 101
        hold_reset();
        clear_rom();
        put(0, ai(7)); put(1, ci(1, C_AP1, 3'b001, 3'b000));
        put(2, ai(2)); put(3, ci(0, C_ZERO, 3'b000, 3'b111));
        release_reset();
        @(posedge Clk);
        #2;
        check("p4_pre_reset_pc", {17'd0, dut.pc_q}, 32'd1);
        Reset = 1'b1;
        #1;
        check("p4_async_pc", {17'd0, dut.pc_q}, 32'd0);
        check("p4_async_a", {16'd0, dut.a_q}, 32'd0);
        check("p4_async_d", {16'd0, dut.d_q}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("p4_we_in_reset", {31'd0, dut.we}, 32'd0);
        end
        push_wr(10'd7, 16'd101);
        Reset = 1'b0;
        wait_pc("p4_halt", 15'd2, 50);
        check("p4_drain", exp_q.size(), 32'd0);

        repeat (2) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
